// File: rtl/slave_pkg.sv
// ============================================================================
//  Module  : slave_pkg
//  Brief   : Shared types, defaults and helpers for the slave-side produce path.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package slave_pkg;

    typedef enum logic [0:0] {ST_FILL, ST_DRAIN} slave_state_e;

    localparam int SLAVE_DEPTH_DFLT = 10;

    // Bit that makes the total number of ones (data plus this bit) even.
    function automatic logic even_parity(input logic [31:0] data);
        return ^data;
    endfunction

endpackage

`default_nettype wire

// File: rtl/slave_consumer.sv
// ============================================================================
//  Module  : slave_consumer
//  Brief   : Fill/drain buffer between the master produce port and a valid/ready
//            consumer. Optional SLAVE_CONSUMER_PARITY_EN adds per-entry parity.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module slave_consumer
    import slave_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int DEPTH  = SLAVE_DEPTH_DFLT,
    parameter int ADDR_W = 4
) (
    input  logic              slave_clk1,
    input  logic              rst_n,
    input  logic              prod_valid,
    input  logic [DATA_W-1:0] prod_data,
    output logic              prod_ready,
    output logic              cons_valid,
    output logic [DATA_W-1:0] cons_data,
    input  logic              cons_ready,
    output logic [ADDR_W-1:0] count,
`ifdef SLAVE_CONSUMER_PARITY_EN
    output logic              parity_err,
`endif
    output logic              drain_done
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    slave_state_e      state;
    slave_state_e      next_state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_en;
    logic              rd_en;

    always_ff @(posedge slave_clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FILL;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        prod_ready = 1'b0;
        cons_valid = 1'b0;
        cons_data  = '0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        case (state)
            ST_FILL: begin
                prod_ready = 1'b1;
                wr_en      = prod_valid;
                if (prod_valid && (count == LAST)) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                cons_valid = 1'b1;
                cons_data  = mem[rd_ptr];
                rd_en      = cons_ready;
                if (cons_ready && (rd_ptr == LAST)) begin
                    next_state = ST_FILL;
                end
            end
            default: next_state = ST_FILL;
        endcase
    end

    // Pointers wrap by explicit compare so non-power-of-2 depths work.
    always_ff @(posedge slave_clk1 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drain_done <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            drain_done <= rd_en && (rd_ptr == LAST);
            if (wr_en) begin
                mem[wr_ptr] <= prod_data;
                count       <= count + 1'b1;
                wr_ptr      <= (count == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_en) begin
                if (rd_ptr == LAST) begin
                    rd_ptr <= '0;
                    count  <= '0;
                end else begin
                    rd_ptr <= rd_ptr + 1'b1;
                    count  <= count - 1'b1;
                end
            end
        end
    end

`ifdef SLAVE_CONSUMER_PARITY_EN
    logic [DEPTH-1:0] mem_par;

    // Data is delivered regardless; a mismatch only latches the sticky flag.
    always_ff @(posedge slave_clk1 or negedge rst_n) begin
        if (!rst_n) begin
            mem_par    <= '0;
            parity_err <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_par[wr_ptr] <= even_parity({{(32-DATA_W){1'b0}}, prod_data});
            end
            if (rd_en && (mem_par[rd_ptr] != even_parity({{(32-DATA_W){1'b0}}, mem[rd_ptr]}))) begin
                parity_err <= 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire
